// File: rtl/bizhang_fsm_pkg.sv
// Shared types for the obstacle-avoidance controller: state codes and motor commands.
package bizhang_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_BACK   = 3'd2,
        ST_TURN_L = 3'd3,
        ST_TURN_R = 3'd4
    } state_e;

    typedef struct packed {
        logic zuo1;
        logic zuo2;
        logic you1;
        logic you2;
        logic en1;
        logic en2;
    } motor_cmd_t;

    localparam motor_cmd_t CMD_STOP   = 6'b00_00_00;
    localparam motor_cmd_t CMD_FWD    = 6'b10_10_11;
    localparam motor_cmd_t CMD_BACK   = 6'b01_01_11;
    localparam motor_cmd_t CMD_TURN_L = 6'b01_10_11;
    localparam motor_cmd_t CMD_TURN_R = 6'b10_01_11;

    function automatic motor_cmd_t cmd_of(input state_e s);
        case (s)
            ST_FWD:    cmd_of = CMD_FWD;
            ST_BACK:   cmd_of = CMD_BACK;
            ST_TURN_L: cmd_of = CMD_TURN_L;
            ST_TURN_R: cmd_of = CMD_TURN_R;
            default:   cmd_of = CMD_STOP;
        endcase
    endfunction

endpackage

// File: rtl/bizhang_fsm_ir_debounce.sv
// One IR channel: two-flop synchroniser plus a stability counter.
// o_lvl_nxt is the level the debouncer will hold after this edge, so the FSM reacts on the same edge.
module ir_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_lvl_nxt
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_lvl;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_lvl_nxt;

    always_comb begin
        w_cnt_nxt = '0;
        w_lvl_nxt = r_lvl;
        if (r_s2 != r_lvl) begin
            if (r_cnt == CW'(DEB_CYCLES - 1)) w_lvl_nxt = r_s2;
            else                              w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= 1'b1;
            r_s2  <= 1'b1;
            r_lvl <= 1'b1;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_din;
            r_s2  <= r_s1;
            r_lvl <= w_lvl_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_lvl_nxt = w_lvl_nxt;

endmodule

// File: rtl/bizhang_fsm.sv
// Reverse-then-turn obstacle avoidance FSM driving an L298-style motor pair.
// Optional BIZHANG_PWM_EN: en1/en2 are chopped by a free-running 8-bit counter against PWM_DUTY.
module bizhang_fsm
    import bizhang_pkg::*;
#(
    parameter int NUM_SENSORS = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int BACK_CYCLES = 25000000,
    parameter int TURN_CYCLES = 15000000,
    parameter int PWM_DUTY    = 192
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   EN_D,
    input  logic [NUM_SENSORS-1:0] din,
    output logic                   zuo1,
    output logic                   zuo2,
    output logic                   you1,
    output logic                   you2,
    output logic                   en1,
    output logic                   en2,
    output logic [2:0]             state,
    output logic [7:0]             evt_cnt
);
    localparam int HALF = NUM_SENSORS / 2;
    localparam int TMAX = (BACK_CYCLES > TURN_CYCLES) ? BACK_CYCLES : TURN_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] BACK_LD = TW'(BACK_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LD = TW'(TURN_CYCLES - 1);

    logic [NUM_SENSORS-1:0] w_lvl;
    logic                   w_obs_l;
    logic                   w_obs_r;
    logic                   w_obs;

    state_e        r_state, w_state_nxt;
    state_e        r_dir,   w_dir_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [7:0]    r_evt,   w_evt_nxt;
    logic          r_alt,   w_alt_nxt;
    logic          w_start;
    motor_cmd_t    r_cmd,   w_cmd_nxt;
    logic          w_pwm_on;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_deb
        ir_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_din     (din[g]),
            .o_lvl_nxt (w_lvl[g])
        );
    end

    assign w_obs_r = |(~w_lvl[HALF-1:0]);
    assign w_obs_l = |(~w_lvl[NUM_SENSORS-1:HALF]);
    assign w_obs   = w_obs_l | w_obs_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dir   <= ST_TURN_L;
            r_timer <= '0;
            r_evt   <= '0;
            r_alt   <= 1'b0;
            r_cmd   <= CMD_STOP;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_timer <= w_timer_nxt;
            r_evt   <= w_evt_nxt;
            r_alt   <= w_alt_nxt;
            r_cmd   <= w_cmd_nxt;
        end
    end

    // Obstacles seen out of IDLE also start a full timed manoeuvre.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_start     = 1'b0;
        if (EN_D) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_obs) w_start = 1'b1;
                    else       w_state_nxt = ST_FWD;
                end
                ST_FWD: begin
                    if (w_obs) w_start = 1'b1;
                end
                ST_BACK: begin
                    if (r_timer == '0) begin
                        w_state_nxt = r_dir;
                        w_timer_nxt = TURN_LD;
                    end else begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end
                ST_TURN_L, ST_TURN_R: begin
                    if (r_timer != '0)  w_timer_nxt = r_timer - 1'b1;
                    else if (w_obs)     w_start     = 1'b1;
                    else                w_state_nxt = ST_FWD;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        if (w_start) begin
            w_state_nxt = ST_BACK;
            w_timer_nxt = BACK_LD;
        end

        w_dir_nxt = r_dir;
        w_alt_nxt = r_alt;
        w_evt_nxt = r_evt;
        if (w_start) begin
            if (r_evt != 8'hFF) w_evt_nxt = r_evt + 8'd1;
            if (w_obs_l && !w_obs_r)      w_dir_nxt = ST_TURN_R;
            else if (w_obs_r && !w_obs_l) w_dir_nxt = ST_TURN_L;
            else begin
                w_dir_nxt = r_alt ? ST_TURN_R : ST_TURN_L;
                w_alt_nxt = ~r_alt;
            end
        end
    end

    always_comb begin
        w_cmd_nxt = cmd_of(w_state_nxt);
    end

`ifdef BIZHANG_PWM_EN
    localparam logic [8:0] DUTY9 = 9'(PWM_DUTY);
    logic [7:0] r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pwm <= '0;
        else        r_pwm <= r_pwm + 8'd1;
    end

    assign w_pwm_on = ({1'b0, r_pwm} < DUTY9);
`else
    assign w_pwm_on = 1'b1;
`endif

    assign zuo1    = r_cmd.zuo1;
    assign zuo2    = r_cmd.zuo2;
    assign you1    = r_cmd.you1;
    assign you2    = r_cmd.you2;
    assign en1     = r_cmd.en1 & w_pwm_on;
    assign en2     = r_cmd.en2 & w_pwm_on;
    assign state   = r_state;
    assign evt_cnt = r_evt;

endmodule

// File: tb/tb_bizhang_fsm.sv
// Bench for bizhang_fsm: directed scenarios plus random sensor/EN_D/reset traffic vs a behavioural model.
module tb_bizhang_fsm;
    localparam int NS   = 4;
    localparam int DEB  = 4;
    localparam int BACK = 10;
    localparam int TURN = 6;
    localparam int DUTY = 64;
    localparam int S_IDLE = 0, S_FWD = 1, S_BACK = 2, S_TL = 3, S_TR = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          EN_D  = 1'b0;
    logic [NS-1:0] din   = '1;
    logic          zuo1, zuo2, you1, you2, en1, en2;
    logic [2:0]    state;
    logic [7:0]    evt_cnt;

    int errs   = 0;
    int checks = 0;

    bizhang_fsm #(
        .NUM_SENSORS (NS),
        .DEB_CYCLES  (DEB),
        .BACK_CYCLES (BACK),
        .TURN_CYCLES (TURN),
        .PWM_DUTY    (DUTY)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .EN_D    (EN_D),
        .din     (din),
        .zuo1    (zuo1),
        .zuo2    (zuo2),
        .you1    (you1),
        .you2    (you2),
        .en1     (en1),
        .en2     (en2),
        .state   (state),
        .evt_cnt (evt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] bits();
        return {zuo1, zuo2, you1, you2, en1, en2};
    endfunction

    // Behavioural model: pin history decides debounced levels, remaining-cycle count drives phases.
    logic [NS-1:0] hist[$];
    logic [NS-1:0] mlvl;
    int  mst, mleft, mevt, mdir, mpwm;
    bit  malt, ol, orr, flip;

    function automatic logic [5:0] exp_cmd(input int st, input int pwm);
        logic [5:0] c;
        case (st)
            S_FWD:   c = 6'b101011;
            S_BACK:  c = 6'b010111;
            S_TL:    c = 6'b011011;
            S_TR:    c = 6'b100111;
            default: c = 6'b000000;
        endcase
`ifdef BIZHANG_PWM_EN
        if (pwm >= DUTY) c[1:0] = 2'b00;
`endif
        return c;
    endfunction

    task automatic m_start();
        mst   = S_BACK;
        mleft = BACK;
        if (mevt < 255) mevt++;
        if (ol && !orr)      mdir = S_TR;
        else if (orr && !ol) mdir = S_TL;
        else begin
            mdir = malt ? S_TR : S_TL;
            malt = !malt;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            hist = {};
            for (int k = 0; k <= DEB; k++) hist.push_back('1);
            mlvl = '1; mst = S_IDLE; mleft = 0; mevt = 0; malt = 0; mdir = S_TL; mpwm = 0;
        end else begin
            mpwm = (mpwm + 1) % 256;
            // a level flips once the last DEB synchronised samples all disagree with it
            for (int ch = 0; ch < NS; ch++) begin
                flip = 1'b1;
                for (int k = 1; k <= DEB; k++) if (hist[k][ch] == mlvl[ch]) flip = 1'b0;
                if (flip) mlvl[ch] = ~mlvl[ch];
            end
            hist.push_front(din);
            void'(hist.pop_back());
            ol  = !(&mlvl[NS-1:NS/2]);
            orr = !(&mlvl[NS/2-1:0]);
            if (EN_D) begin
                mst = S_IDLE; mleft = 0;
            end else begin
                case (mst)
                    S_IDLE: if (ol || orr) m_start(); else mst = S_FWD;
                    S_FWD:  if (ol || orr) m_start();
                    S_BACK: begin
                        mleft--;
                        if (mleft == 0) begin mst = mdir; mleft = TURN; end
                    end
                    default: begin
                        mleft--;
                        if (mleft == 0) begin
                            if (ol || orr) m_start(); else mst = S_FWD;
                        end
                    end
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("state", 32'(state), 32'(mst));
        chk("evt_cnt", 32'(evt_cnt), 32'(mevt));
        chk("motor", 32'(bits()), 32'(exp_cmd(mst, mpwm)));
        chk("safety", {30'd0, zuo1 & zuo2, you1 & you2}, 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_st(input int st, output int n);
        n = 0;
        while (32'(state) != st && n < 60) begin step(); n++; end
    endtask

    task automatic dwell(input int st, output int n);
        n = 1;
        while (32'(state) == st && n < 60) begin
            step();
            if (32'(state) == st) n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        int n, hold, cnt;
        repeat (3) @(negedge clk);
        chk("rst_motor", 32'(bits()), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_evt", 32'(evt_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        chk("fwd_state", 32'(state), 32'd1);
        chk("fwd_motor", 32'(bits()), 32'b101011);

        // glitch shorter than the debounce window
        @(negedge clk) din = 4'b1110;
        repeat (3) @(negedge clk);
        din = 4'hF;
        repeat (10) step();
        chk("glitch_state", 32'(state), 32'd1);
        chk("glitch_evt", 32'(evt_cnt), 32'd0);

        // right-side obstacle
        @(negedge clk) din = 4'b1110;
        wait_st(S_BACK, n);
        chk("back_latency", n, 6);
        @(negedge clk) din = 4'hF;
        dwell(S_BACK, n);
        chk("back_len", n, BACK);
        chk("turn_l_state", 32'(state), S_TL);
        chk("turn_l_motor", 32'(bits()), 32'b011011);
        dwell(S_TL, n);
        chk("turn_len", n, TURN);
        chk("fwd_again", 32'(state), S_FWD);
        chk("evt_one", 32'(evt_cnt), 32'd1);

        // both sides: alternation TURN_L then TURN_R
        @(negedge clk) din = 4'b0101;
        wait_st(S_BACK, n);
        chk("both_evt2", 32'(evt_cnt), 32'd2);
        dwell(S_BACK, n);
        chk("both_first_tl", 32'(state), S_TL);
        dwell(S_TL, n);
        chk("both_reback", 32'(state), S_BACK);
        chk("both_evt3", 32'(evt_cnt), 32'd3);
        @(negedge clk) din = 4'hF;
        dwell(S_BACK, n);
        chk("both_second_tr", 32'(state), S_TR);
        chk("turn_r_motor", 32'(bits()), 32'b100111);
        dwell(S_TR, n);
        chk("both_fwd", 32'(state), S_FWD);

        // EN_D during BACK cycle 5
        @(negedge clk) din = 4'b1011;
        wait_st(S_BACK, n);
        repeat (4) step();
        @(negedge clk) begin EN_D = 1'b1; din = 4'hF; end
        step();
        chk("en_d_state", 32'(state), 32'd0);
        chk("en_d_motor", 32'(bits()), 32'd0);
        repeat (8) step();
        @(negedge clk) EN_D = 1'b0;
        step();
        chk("en_d_release", 32'(state), S_FWD);

        // enable duty over one full PWM period
        cnt = 0;
        repeat (256) begin step(); cnt += int'(en1); end
`ifdef BIZHANG_PWM_EN
        chk("pwm_duty", cnt, DUTY);
`else
        chk("en_steady", cnt, 256);
`endif

        // asynchronous reset mid-manoeuvre
        @(negedge clk) din = 4'b1110;
        wait_st(S_BACK, n);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("async_rst_motor", 32'(bits()), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        din = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("restart_fwd", 32'(state), S_FWD);

        // random traffic, checked every cycle by the model
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                din  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 14);
            end else begin
                hold--;
            end
            EN_D  = ($urandom_range(0, 59) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk) begin rst_n = 1'b1; EN_D = 1'b0; din = 4'hF; end
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
